alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, parametrised successor to the datapath ALU.
- Adds shifts, XOR, unsigned compare, signed-overflow detection, and an iterative multiply/divide unit with HI/LO registers.
- Sits in the EX stage. Operands are accepted with a valid/ready handshake, and results return with a one-cycle out_valid pulse.
- Single-cycle ops complete in 1 cycle; mul/div stall the pipeline via in_ready.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥4 and even. Shift amount uses the low clog2(WIDTH) bits of in2.
- MULDIV_EN, 1, when 0 the mul/div unit is not built and codes 1010, 1011, 1101, 1110 behave as reserved.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands and op valid this cycle
- in_ready  output  1  block can accept; equals "state is IDLE"
- alu_control  input  4  operation code
- in1  input  WIDTH  operand A (rs)
- in2  input  WIDTH  operand B (rt / immediate / shamt)
- out  output  WIDTH  registered result
- out_valid  output  1  one-cycle pulse when out/flags/hi/lo are updated
- zero_flag  output  1  registered (out == 0)
- ovf_flag  output  1  registered signed overflow (ADD/SUB only, else 0)
- div_by_zero  output  1  registered; 1 only on a DIV/DIVU completion with in2 == 0
- hi  output  WIDTH  HI register (product high / remainder)
- lo  output  WIDTH  LO register (product low / quotient)

Behaviour:
- Reset (sync): all outputs, hi and lo go to 0, and state goes to IDLE. in_ready is 0 during the reset cycle and 1 from the following cycle.
- Reset mid-mul/div aborts the operation: no out_valid, and hi/lo are cleared.
- Accept: a transfer occurs on a rising edge with in_valid && in_ready. in_valid while in_ready=0 is ignored, not queued.
- Opcodes, single-cycle:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR.
  - 0100 SLL in1<<sh; 0101 SRL in1>>sh (logical); 0110 SUB in1−in2.
  - 0111 SLT signed (1:0); 1000 SRA in1>>>sh; 1001 SLTU unsigned; 1100 NOR.
  - 1111 and disabled mul/div codes are reserved: out=0.
- Single-cycle latency: result, zero_flag and ovf_flag are registered on the accept edge. out_valid=1 for the cycle after. in_ready stays 1, so back-to-back issue is allowed every cycle. hi/lo are unchanged.
- Multi-cycle opcodes: 1010 MULT (signed), 1011 MULTU, 1101 DIV (signed), 1110 DIVU.
- FSM for multi-cycle ops: IDLE → ITER (accept edge) → FIX (after WIDTH ITER edges) → IDLE.
  - ITER: one shift-add (mul) or restoring shift-subtract (div) step per cycle, on magnitudes.
  - FIX: apply sign correction.
  - On the FIX→IDLE edge, register hi, lo, out=lo, zero_flag=(lo==0), ovf_flag=0 and div_by_zero. out_valid=1 the following cycle.
  - in_ready=0 throughout ITER and FIX.
  - Total latency: out_valid is seen exactly WIDTH+1 edges after the accept edge.
- MULT/MULTU: {hi,lo} = full 2·WIDTH-bit product.
- DIV/DIVU: lo=quotient, hi=remainder. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Signed MIN / −1: lo=MIN, hi=0, no flag.
- Divide by zero: lo=all ones, hi=in1, div_by_zero=1; still takes full latency.
- out_valid is 0 except the single cycle after completion. out and flags hold their last values when out_valid=0.

Test Plan:
(WIDTH=32 unless noted)
- ADD 0x7FFFFFFF + 0x00000001 → next cycle out_valid=1, out=0x80000000, ovf_flag=1, zero_flag=0. SUB 5−5 in the following cycle → out=0, zero_flag=1, ovf_flag=0 (back-to-back issue).
- SLT 0xFFFFFFFF vs 0x00000001 → out=1; SLTU same operands → out=0. SRA 0x80000000 by in2=0x24 (sh=4) → 0xF8000000; SRL → 0x08000000.
- MULT in1=−3 (0xFFFFFFFD), in2=7 → in_ready=0 for 33 cycles, then out_valid exactly 33 edges after accept. Result: hi=0xFFFFFFFF, lo=0xFFFFFFEB, out=0xFFFFFFEB.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → lo=0xFFFFFFFF, hi=0x00000007, div_by_zero=1. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Assert reset at the 10th ITER cycle of MULTU 0xFFFFFFFF·0xFFFFFFFF → no out_valid, hi=lo=0, in_ready=1 the cycle after reset deasserts. A following ADD 2+3 → out=5.
- Drive ADD with in_valid during a busy DIVU → ignored, no extra out_valid. With MULDIV_EN=0, MULT 3·4 → out=0, zero_flag=1 after 1 cycle, and hi/lo unchanged.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with valid/ready operand handshake.
// Single-cycle ops retire one cycle after acceptance. MULT/MULTU/DIV/DIVU
// run an iterative magnitude engine (shift-add / restoring shift-subtract),
// one bit per cycle, followed by a sign-fix cycle that writes hi/lo.
module alu_seq #(
  parameter int WIDTH     = 32,
  parameter int MULDIV_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zero_flag,
  output logic             ovf_flag,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MULT  = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic             accept;
  logic             is_muldiv;
  logic             op_signed;
  logic             op_is_mul;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [SHW-1:0]   sh;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum, dif;

  // Iterative engine state: acc holds the running high half (mul) or the
  // partial remainder (div); mq holds the multiplier / quotient bits.
  logic [SHW-1:0]   cnt;
  logic             mul_mode;
  logic             neg_q, neg_r;
  logic             dbz_pend;
  logic [WIDTH-1:0] acc, mq, mcand, dividend_raw;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  assign in_ready = (state == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign sh       = in2[SHW-1:0];

  // Decode which opcodes go to the multi-cycle engine and how to treat signs.
  always_comb begin
    is_muldiv = 1'b0;
    op_signed = 1'b0;
    op_is_mul = 1'b0;
    if (MULDIV_EN != 0) begin
      case (alu_control)
        OP_MULT:  begin is_muldiv = 1'b1; op_signed = 1'b1; op_is_mul = 1'b1; end
        OP_MULTU: begin is_muldiv = 1'b1; op_is_mul = 1'b1; end
        OP_DIV:   begin is_muldiv = 1'b1; op_signed = 1'b1; end
        OP_DIVU:  begin is_muldiv = 1'b1; end
        default:  ;
      endcase
    end
    a_neg = op_signed && in1[WIDTH-1];
    b_neg = op_signed && in2[WIDTH-1];
    mag_a = a_neg ? (~in1 + 1'b1) : in1;
    mag_b = b_neg ? (~in2 + 1'b1) : in2;
  end

  // Single-cycle result and signed overflow; reserved codes produce zero.
  always_comb begin
    sum     = in1 + in2;
    dif     = in1 - in2;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_control)
      OP_AND:  alu_res = in1 & in2;
      OP_OR:   alu_res = in1 | in2;
      OP_XOR:  alu_res = in1 ^ in2;
      OP_NOR:  alu_res = ~(in1 | in2);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif;
        alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (dif[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SLL:  alu_res = in1 << sh;
      OP_SRL:  alu_res = in1 >> sh;
      OP_SRA:  alu_res = $signed(in1) >>> sh;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      default: alu_res = '0;
    endcase
  end

  // One engine step (mul: shift-add, div: restoring shift-subtract) plus the
  // sign-corrected final hi/lo used on the FIX cycle.
  always_comb begin
    mul_sum = {1'b0, acc} + {1'b0, (mq[0] ? mcand : {WIDTH{1'b0}})};
    rem_sh  = {acc, mq[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, mcand});
    rem_sub = rem_sh[WIDTH-1:0] - mcand;

    prod     = {acc, mq};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    q_fix    = neg_q ? (~mq + 1'b1) : mq;
    r_fix    = neg_r ? (~acc + 1'b1) : acc;

    fin_hi = r_fix;
    fin_lo = q_fix;
    if (mul_mode) begin
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
      fin_lo = prod_fix[WIDTH-1:0];
    end else if (dbz_pend) begin
      fin_hi = dividend_raw;
      fin_lo = '1;
    end
  end

  // Next-state logic for the multi-cycle sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_muldiv) state_next = ITER;
      ITER:    if (cnt == LAST_STEP) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath: retire single-cycle ops, load/step the engine, publish results.
  always_ff @(posedge clk) begin
    if (reset) begin
      out          <= '0;
      out_valid    <= 1'b0;
      zero_flag    <= 1'b0;
      ovf_flag     <= 1'b0;
      div_by_zero  <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      cnt          <= '0;
      mul_mode     <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dbz_pend     <= 1'b0;
      acc          <= '0;
      mq           <= '0;
      mcand        <= '0;
      dividend_raw <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_muldiv) begin
              cnt          <= '0;
              mul_mode     <= op_is_mul;
              neg_q        <= a_neg ^ b_neg;
              neg_r        <= a_neg && !op_is_mul;
              dbz_pend     <= !op_is_mul && (in2 == '0);
              acc          <= '0;
              mq           <= mag_a;
              mcand        <= mag_b;
              dividend_raw <= in1;
            end else begin
              out         <= alu_res;
              zero_flag   <= (alu_res == '0);
              ovf_flag    <= alu_ovf;
              div_by_zero <= 1'b0;
              out_valid   <= 1'b1;
            end
          end
        end
        ITER: begin
          cnt <= cnt + SHW'(1);
          if (mul_mode) begin
            acc <= mul_sum[WIDTH:1];
            mq  <= {mul_sum[0], mq[WIDTH-1:1]};
          end else if (rem_ge) begin
            acc <= rem_sub;
            mq  <= {mq[WIDTH-2:0], 1'b1};
          end else begin
            acc <= rem_sh[WIDTH-1:0];
            mq  <= {mq[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          hi          <= fin_hi;
          lo          <= fin_lo;
          out         <= fin_lo;
          zero_flag   <= (fin_lo == '0);
          ovf_flag    <= 1'b0;
          div_by_zero <= dbz_pend;
          out_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq, with a second
// instance built without the mul/div unit.
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        in_valid, in_valid0;
  logic [3:0]  alu_control;
  logic [31:0] in1, in2;

  logic        in_ready, out_valid, zero_flag, ovf_flag, div_by_zero;
  logic [31:0] out, hi, lo;
  logic        in_ready0, out_valid0, zero_flag0, ovf_flag0, div_by_zero0;
  logic [31:0] out0, hi0, lo0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ovf;
  } vec_t;

  vec_t vecs[18];

  alu_seq #(.WIDTH(32), .MULDIV_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .in1(in1), .in2(in2), .out(out),
    .out_valid(out_valid), .zero_flag(zero_flag), .ovf_flag(ovf_flag),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  alu_seq #(.WIDTH(32), .MULDIV_EN(0)) dut_nomd (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .alu_control(alu_control), .in1(in1), .in2(in2), .out(out0),
    .out_valid(out_valid0), .zero_flag(zero_flag0), .ovf_flag(ovf_flag0),
    .div_by_zero(div_by_zero0), .hi(hi0), .lo(lo0)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    alu_control = op;
    in1         = a;
    in2         = b;
  endtask

  // Advance until out_valid is seen; counts edges and cycles spent with in_ready low.
  task automatic wait_done(output int edges, output int busy);
    edges = 0;
    busy  = 0;
    while (out_valid !== 1'b1 && edges < 100) begin
      if (in_ready === 1'b0) busy++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0;
    alu_control = 4'h0; in1 = '0; in2 = '0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if ({out_valid, zero_flag, ovf_flag, div_by_zero} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {out_valid, zero_flag, ovf_flag, div_by_zero}); end
    checks++; if ({out, hi, lo} !== 96'h0) begin errors++; $display("[TB] FAIL reset_regs: got out=%h hi=%h lo=%h expected all 0", out, hi, lo); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add_sub_b2b;
    drive(4'b0010, 32'h7FFFFFFF, 32'h00000001);
    @(posedge clk); #1;
    checks++; if ({out_valid, out, ovf_flag, zero_flag} !== {1'b1, 32'h80000000, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL add_ovf: got v=%b out=%h ovf=%b z=%b expected v=1 out=80000000 ovf=1 z=0", out_valid, out, ovf_flag, zero_flag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL add_ready: got %b expected 1", in_ready); end
    drive(4'b0110, 32'd5, 32'd5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({out_valid, out, ovf_flag, zero_flag} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL sub_zero: got v=%b out=%h ovf=%b z=%b expected v=1 out=0 ovf=0 z=1", out_valid, out, ovf_flag, zero_flag); end
    @(posedge clk); #1;
    checks++; if ({out_valid, out, zero_flag} !== {1'b0, 32'h0, 1'b1}) begin errors++; $display("[TB] FAIL idle_hold: got v=%b out=%h z=%b expected v=0 out=0 z=1", out_valid, out, zero_flag); end
  endtask

  task automatic test_single_cycle;
    vecs[0]  = '{4'b0000, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0};
    vecs[1]  = '{4'b0001, 32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 1'b0};
    vecs[2]  = '{4'b0011, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0};
    vecs[3]  = '{4'b1100, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00F000F0, 1'b0};
    vecs[4]  = '{4'b0100, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0};
    vecs[5]  = '{4'b0100, 32'h80000001, 32'h0000001F, 32'h80000000, 1'b0};
    vecs[6]  = '{4'b1000, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0};
    vecs[7]  = '{4'b0101, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0};
    vecs[8]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[9]  = '{4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[10] = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[11] = '{4'b1001, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[12] = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    vecs[13] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[14] = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0};
    vecs[15] = '{4'b1000, 32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1'b0};
    vecs[16] = '{4'b0110, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[17] = '{4'b0010, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    drive(vecs[0].op, vecs[0].a, vecs[0].b);
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out, ovf_flag, zero_flag} !== {1'b1, vecs[i].exp, vecs[i].ovf, (vecs[i].exp == 32'h0)}) begin
        errors++;
        $display("[TB] FAIL vec%0d op=%b: got v=%b out=%h ovf=%b z=%b expected v=1 out=%h ovf=%b z=%b",
                 i, vecs[i].op, out_valid, out, ovf_flag, zero_flag, vecs[i].exp, vecs[i].ovf, (vecs[i].exp == 32'h0));
      end
      if (i < 17) drive(vecs[i+1].op, vecs[i+1].a, vecs[i+1].b);
      else        in_valid = 1'b0;
    end
  endtask

  task automatic test_mult;
    int edges, busy;
    drive(4'b1010, 32'hFFFFFFFD, 32'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(edges, busy);
    checks++; if (edges !== 33) begin errors++; $display("[TB] FAIL mult_latency: got %0d edges expected 33", edges); end
    checks++; if (busy !== 33) begin errors++; $display("[TB] FAIL mult_busy: got %0d cycles not ready expected 33", busy); end
    checks++; if ({hi, lo, out} !== {32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFEB}) begin errors++; $display("[TB] FAIL mult_result: got hi=%h lo=%h out=%h expected FFFFFFFF FFFFFFEB FFFFFFEB", hi, lo, out); end
    checks++; if ({zero_flag, ovf_flag, div_by_zero, in_ready} !== 4'b0001) begin errors++; $display("[TB] FAIL mult_flags: got %b expected 0001", {zero_flag, ovf_flag, div_by_zero, in_ready}); end
    drive(4'b0010, 32'd2, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({out_valid, out, hi, lo} !== {1'b1, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFEB}) begin errors++; $display("[TB] FAIL add_after_mult: got v=%b out=%h hi=%h lo=%h expected 1 5 FFFFFFFF FFFFFFEB", out_valid, out, hi, lo); end
    drive(4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(edges, busy);
    checks++; if ({edges == 33, hi, lo} !== {1'b1, 32'hFFFFFFFE, 32'h00000001}) begin errors++; $display("[TB] FAIL multu_max: got edges=%0d hi=%h lo=%h expected 33 FFFFFFFE 00000001", edges, hi, lo); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mult_pulse_width: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_div;
    int edges, busy;
    logic [31:0] da[5], db[5], eh[5], el[5];
    logic [3:0]  dop[5];
    logic        edbz[5];
    dop[0] = 4'b1101; da[0] = 32'hFFFFFFF9; db[0] = 32'd2;        eh[0] = 32'hFFFFFFFF; el[0] = 32'hFFFFFFFD; edbz[0] = 1'b0;
    dop[1] = 4'b1110; da[1] = 32'd7;        db[1] = 32'd0;        eh[1] = 32'h00000007; el[1] = 32'hFFFFFFFF; edbz[1] = 1'b1;
    dop[2] = 4'b1101; da[2] = 32'h80000000; db[2] = 32'hFFFFFFFF; eh[2] = 32'h00000000; el[2] = 32'h80000000; edbz[2] = 1'b0;
    dop[3] = 4'b1101; da[3] = 32'd7;        db[3] = 32'hFFFFFFFE; eh[3] = 32'h00000001; el[3] = 32'hFFFFFFFD; edbz[3] = 1'b0;
    dop[4] = 4'b1110; da[4] = 32'd100;      db[4] = 32'd7;        eh[4] = 32'h00000002; el[4] = 32'h0000000E; edbz[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(dop[i], da[i], db[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done(edges, busy);
      checks++;
      if ({edges == 33, hi, lo, out, div_by_zero, ovf_flag} !== {1'b1, eh[i], el[i], el[i], edbz[i], 1'b0}) begin
        errors++;
        $display("[TB] FAIL div%0d: got edges=%0d hi=%h lo=%h out=%h dbz=%b ovf=%b expected 33 %h %h %h %b 0",
                 i, edges, hi, lo, out, div_by_zero, ovf_flag, eh[i], el[i], el[i], edbz[i]);
      end
      if (i == 1) begin
        drive(4'b0010, 32'd1, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if ({out_valid, out, div_by_zero} !== {1'b1, 32'd2, 1'b0}) begin errors++; $display("[TB] FAIL dbz_clear: got v=%b out=%h dbz=%b expected 1 2 0", out_valid, out, div_by_zero); end
      end
    end
  endtask

  task automatic test_reset_mid_mul;
    int pulses = 0;
    drive(4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    checks++; if ({in_ready, out_valid} !== 2'b00) begin errors++; $display("[TB] FAIL mid_reset_busy: got ready=%b v=%b expected 0 0", in_ready, out_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid, hi, lo} !== {1'b1, 1'b0, 64'h0}) begin errors++; $display("[TB] FAIL mid_reset_state: got ready=%b v=%b hi=%h lo=%h expected 1 0 0 0", in_ready, out_valid, hi, lo); end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL mid_reset_no_pulse: got %0d pulses expected 0", pulses); end
    drive(4'b0010, 32'd2, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({out_valid, out, hi, lo} !== {1'b1, 32'd5, 64'h0}) begin errors++; $display("[TB] FAIL add_after_reset: got v=%b out=%h hi=%h lo=%h expected 1 5 0 0", out_valid, out, hi, lo); end
  endtask

  task automatic test_ignore_busy;
    int pulses = 0;
    int pulse_edge = -1;
    logic [31:0] pulse_out = '0;
    drive(4'b1110, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(4'b0010, 32'd1, 32'd1);
    for (int k = 1; k <= 60; k++) begin
      if (k == 6) in_valid = 1'b0;
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        pulses++;
        pulse_edge = k;
        pulse_out  = out;
      end
    end
    checks++; if (pulses !== 1 || pulse_edge !== 33) begin errors++; $display("[TB] FAIL busy_ignore_pulses: got %0d pulses last at edge %0d expected 1 at 33", pulses, pulse_edge); end
    checks++; if ({pulse_out, hi, lo} !== {32'd14, 32'd2, 32'd14}) begin errors++; $display("[TB] FAIL busy_ignore_result: got out=%h hi=%h lo=%h expected E 2 E", pulse_out, hi, lo); end
  endtask

  task automatic test_muldiv_disabled;
    in_valid0 = 1'b1; alu_control = 4'b0010; in1 = 32'd2; in2 = 32'd3;
    @(posedge clk); #1;
    checks++; if ({out_valid0, out0, zero_flag0} !== {1'b1, 32'd5, 1'b0}) begin errors++; $display("[TB] FAIL nomd_add: got v=%b out=%h z=%b expected 1 5 0", out_valid0, out0, zero_flag0); end
    alu_control = 4'b1010; in1 = 32'd3; in2 = 32'd4;
    @(posedge clk); #1;
    checks++; if ({out_valid0, out0, zero_flag0, in_ready0} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL nomd_mult: got v=%b out=%h z=%b ready=%b expected 1 0 1 1", out_valid0, out0, zero_flag0, in_ready0); end
    checks++; if ({hi0, lo0} !== 64'h0) begin errors++; $display("[TB] FAIL nomd_hilo: got hi=%h lo=%h expected 0 0", hi0, lo0); end
    alu_control = 4'b1110; in1 = 32'd7; in2 = 32'd0;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    checks++; if ({out_valid0, out0, div_by_zero0, hi0, lo0} !== {1'b1, 32'd0, 1'b0, 64'h0}) begin errors++; $display("[TB] FAIL nomd_divu: got v=%b out=%h dbz=%b hi=%h lo=%h expected 1 0 0 0 0", out_valid0, out0, div_by_zero0, hi0, lo0); end
    @(posedge clk); #1;
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL nomd_pulse: got %b expected 0", out_valid0); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset;
    test_add_sub_b2b;
    test_single_cycle;
    test_mult;
    test_div;
    test_reset_mid_mul;
    test_ignore_busy;
    test_muldiv_disabled;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
